// File: rtl/reservation_station.sv
// Reservation station: holds dispatched ALU ops, captures ROB results, issues the lowest ready entry.
// Optional macro RS_DISPATCH_BYPASS_EN: resolve a not-ready source from the ROB at the dispatch edge.
module reservation_station #(
  parameter int unsigned rs_size        = 16,
  parameter int unsigned rs_index_bits  = 4,
  parameter int unsigned rob_size       = 16,
  parameter int unsigned rob_index_bits = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               load_rs_dec,
  input  logic [3:0]                         op_dec,
  input  logic                               src1_rdy_dec,
  input  logic                               src2_rdy_dec,
  input  logic [31:0]                        src1_dec,
  input  logic [31:0]                        src2_dec,
  output logic [31:0]                        rsidx_alloc,
  output logic                               rs_full,
  input  logic [rob_size-1:0]                done_rob,
  input  logic [rob_size-1:0][31:0]          data_rob,
  output logic                               fu_valid,
  input  logic                               fu_ready,
  output logic [3:0]                         fu_op,
  output logic [31:0]                        fu_a,
  output logic [31:0]                        fu_b,
  output logic [rs_index_bits-1:0]           fu_tag,
  input  logic                               fu_done,
  input  logic [rs_index_bits-1:0]           fu_done_tag,
  input  logic [31:0]                        fu_result,
  output logic [rs_size-1:0]                 done_rs,
  output logic [rs_size-1:0][31:0]           data_rs
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;

  logic [rs_size-1:0]             busy;
  logic [rs_size-1:0]             issued;
  logic [rs_size-1:0]             done;
  logic [rs_size-1:0]             rdy1;
  logic [rs_size-1:0]             rdy2;
  logic [rs_size-1:0][OP_W-1:0]   op;
  logic [rs_size-1:0][DATA_W-1:0] val1;
  logic [rs_size-1:0][DATA_W-1:0] val2;
  logic [rs_size-1:0][DATA_W-1:0] result;

  logic [rs_index_bits-1:0] alloc_idx;
  logic [rs_index_bits-1:0] sel_idx;
  logic [rs_size-1:0]       ready_vec;
  logic                     dispatch;
  logic                     issue_fire;
  logic                     d_rdy1;
  logic                     d_rdy2;
  logic [DATA_W-1:0]        d_val1;
  logic [DATA_W-1:0]        d_val2;

  // Lowest free entry for allocation; built from registered busy so frees show a cycle late.
  always_comb begin
    alloc_idx = '0;
    for (int i = rs_size - 1; i >= 0; i--) begin
      if (!busy[i]) alloc_idx = rs_index_bits'(i);
    end
  end

  assign rs_full     = &busy;
  assign rsidx_alloc = DATA_W'(alloc_idx);
  assign dispatch    = load_rs_dec && !rs_full;

  // Issue selection uses registered readiness, so a captured operand issues the next cycle.
  assign ready_vec = busy & ~issued & rdy1 & rdy2;

  always_comb begin
    sel_idx = '0;
    for (int i = rs_size - 1; i >= 0; i--) begin
      if (ready_vec[i]) sel_idx = rs_index_bits'(i);
    end
  end

  assign fu_valid   = |ready_vec;
  assign issue_fire = fu_valid && fu_ready;
  assign fu_op      = fu_valid ? op[sel_idx]   : '0;
  assign fu_a       = fu_valid ? val1[sel_idx] : '0;
  assign fu_b       = fu_valid ? val2[sel_idx] : '0;
  assign fu_tag     = fu_valid ? sel_idx       : '0;

  assign done_rs = done;
  assign data_rs = result;

  // Operand values as they will be stored by a dispatch this cycle.
  always_comb begin
    d_rdy1 = src1_rdy_dec;
    d_val1 = src1_dec;
    d_rdy2 = src2_rdy_dec;
    d_val2 = src2_dec;
`ifdef RS_DISPATCH_BYPASS_EN
    if (!src1_rdy_dec && done_rob[src1_dec[rob_index_bits-1:0]]) begin
      d_rdy1 = 1'b1;
      d_val1 = data_rob[src1_dec[rob_index_bits-1:0]];
    end
    if (!src2_rdy_dec && done_rob[src2_dec[rob_index_bits-1:0]]) begin
      d_rdy2 = 1'b1;
      d_val2 = data_rob[src2_dec[rob_index_bits-1:0]];
    end
`endif
  end

  // Per-entry update; each event targets disjoint state or disjoint entries, so all apply together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy   <= '0;
      issued <= '0;
      done   <= '0;
      rdy1   <= '0;
      rdy2   <= '0;
      op     <= '0;
      val1   <= '0;
      val2   <= '0;
      result <= '0;
    end else begin
      for (int i = 0; i < rs_size; i++) begin
        if (busy[i] && !rdy1[i] && done_rob[val1[i][rob_index_bits-1:0]]) begin
          rdy1[i] <= 1'b1;
          val1[i] <= data_rob[val1[i][rob_index_bits-1:0]];
        end
        if (busy[i] && !rdy2[i] && done_rob[val2[i][rob_index_bits-1:0]]) begin
          rdy2[i] <= 1'b1;
          val2[i] <= data_rob[val2[i][rob_index_bits-1:0]];
        end
        if (issue_fire && sel_idx == rs_index_bits'(i)) begin
          issued[i] <= 1'b1;
        end
        if (fu_done && fu_done_tag == rs_index_bits'(i) && busy[i] && issued[i]) begin
          done[i]   <= 1'b1;
          result[i] <= fu_result;
        end
        // A completed entry retires one cycle after its done pulse appears.
        if (done[i]) begin
          busy[i] <= 1'b0;
          done[i] <= 1'b0;
        end
        if (dispatch && alloc_idx == rs_index_bits'(i)) begin
          busy[i]   <= 1'b1;
          issued[i] <= 1'b0;
          done[i]   <= 1'b0;
          op[i]     <= op_dec;
          rdy1[i]   <= d_rdy1;
          val1[i]   <= d_val1;
          rdy2[i]   <= d_rdy2;
          val2[i]   <= d_val2;
        end
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed self-checking bench for reservation_station (16 entries, 16 ROB entries).
module tb_reservation_station;

  logic              clk;
  logic              rst;
  logic              load_rs_dec;
  logic [3:0]        op_dec;
  logic              src1_rdy_dec;
  logic              src2_rdy_dec;
  logic [31:0]       src1_dec;
  logic [31:0]       src2_dec;
  logic [31:0]       rsidx_alloc;
  logic              rs_full;
  logic [15:0]       done_rob;
  logic [15:0][31:0] data_rob;
  logic              fu_valid;
  logic              fu_ready;
  logic [3:0]        fu_op;
  logic [31:0]       fu_a;
  logic [31:0]       fu_b;
  logic [3:0]        fu_tag;
  logic              fu_done;
  logic [3:0]        fu_done_tag;
  logic [31:0]       fu_result;
  logic [15:0]       done_rs;
  logic [15:0][31:0] data_rs;

  int tests_run;
  int tests_failed;

  reservation_station #(
    .rs_size(16), .rs_index_bits(4), .rob_size(16), .rob_index_bits(4)
  ) dut (
    .clk(clk), .rst(rst),
    .load_rs_dec(load_rs_dec), .op_dec(op_dec),
    .src1_rdy_dec(src1_rdy_dec), .src2_rdy_dec(src2_rdy_dec),
    .src1_dec(src1_dec), .src2_dec(src2_dec),
    .rsidx_alloc(rsidx_alloc), .rs_full(rs_full),
    .done_rob(done_rob), .data_rob(data_rob),
    .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_op(fu_op),
    .fu_a(fu_a), .fu_b(fu_b), .fu_tag(fu_tag),
    .fu_done(fu_done), .fu_done_tag(fu_done_tag), .fu_result(fu_result),
    .done_rs(done_rs), .data_rs(data_rs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    load_rs_dec  = 1'b0;
    op_dec       = '0;
    src1_rdy_dec = 1'b0;
    src2_rdy_dec = 1'b0;
    src1_dec     = '0;
    src2_dec     = '0;
    done_rob     = '0;
    data_rob     = '0;
    fu_ready     = 1'b0;
    fu_done      = 1'b0;
    fu_done_tag  = '0;
    fu_result    = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic dispatch(input logic [3:0] op, input logic r1, input logic [31:0] s1,
                          input logic r2, input logic [31:0] s2);
    load_rs_dec  = 1'b1;
    op_dec       = op;
    src1_rdy_dec = r1;
    src1_dec     = s1;
    src2_rdy_dec = r2;
    src2_dec     = s2;
    tick();
    load_rs_dec  = 1'b0;
    op_dec       = '0;
    src1_rdy_dec = 1'b0;
    src2_rdy_dec = 1'b0;
    src1_dec     = '0;
    src2_dec     = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    #3;
    tests_run++;
    if (rs_full !== 1'b0 || rsidx_alloc !== 32'd0 || fu_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: rs_full=%b alloc=%0d fu_valid=%b, want 0/0/0", rs_full, rsidx_alloc, fu_valid);
    end
    tests_run++;
    if (done_rs !== 16'h0 || data_rs !== '0 || fu_a !== 32'd0 || fu_b !== 32'd0 || fu_op !== 4'd0 || fu_tag !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_data: done_rs=%h fu_a=%h fu_b=%h fu_op=%h fu_tag=%h, want all 0", done_rs, fu_a, fu_b, fu_op, fu_tag);
    end
    tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_basic_issue();
    do_reset();
    fu_ready = 1'b1;
    tests_run++;
    if (rsidx_alloc !== 32'd0) begin
      tests_failed++;
      $display("FAIL basic_alloc: rsidx_alloc=%0d, want 0", rsidx_alloc);
    end
    dispatch(4'd1, 1'b1, 32'd5, 1'b1, 32'd7);
    tests_run++;
    if (fu_valid !== 1'b1 || fu_op !== 4'd1 || fu_a !== 32'd5 || fu_b !== 32'd7 || fu_tag !== 4'd0) begin
      tests_failed++;
      $display("FAIL basic_issue: valid=%b op=%0d a=%0d b=%0d tag=%0d, want 1/1/5/7/0", fu_valid, fu_op, fu_a, fu_b, fu_tag);
    end
    tick();
    fu_ready = 1'b0;
    tests_run++;
    if (fu_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_issued: fu_valid=%b, want 0", fu_valid);
    end
    fu_done = 1'b1; fu_done_tag = 4'd0; fu_result = 32'h12;
    tick();
    fu_done = 1'b0;
    tests_run++;
    if (done_rs !== 16'h0001 || data_rs[0] !== 32'h12 || rsidx_alloc !== 32'd1) begin
      tests_failed++;
      $display("FAIL basic_done: done_rs=%h data=%h alloc=%0d, want 0001/12/1", done_rs, data_rs[0], rsidx_alloc);
    end
    tick();
    tests_run++;
    if (done_rs !== 16'h0000 || rsidx_alloc !== 32'd0 || data_rs[0] !== 32'h12) begin
      tests_failed++;
      $display("FAIL basic_free: done_rs=%h alloc=%0d data=%h, want 0000/0/12", done_rs, rsidx_alloc, data_rs[0]);
    end
  endtask

  task automatic test_capture();
    do_reset();
    dispatch(4'd2, 1'b0, 32'd3, 1'b1, 32'd1);
    tests_run++;
    if (fu_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL capture_wait: fu_valid=%b, want 0", fu_valid);
    end
    tick();
    done_rob[3] = 1'b1;
    data_rob[3] = 32'h10;
    #1;
    tests_run++;
    if (fu_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL capture_same_cycle: fu_valid=%b, want 0", fu_valid);
    end
    tick();
    done_rob[3] = 1'b0;
    data_rob[3] = '0;
    #1;
    tests_run++;
    if (fu_valid !== 1'b1 || fu_a !== 32'h10 || fu_b !== 32'd1 || fu_op !== 4'd2 || fu_tag !== 4'd0) begin
      tests_failed++;
      $display("FAIL capture_issue: valid=%b a=%h b=%h op=%0d tag=%0d, want 1/10/1/2/0", fu_valid, fu_a, fu_b, fu_op, fu_tag);
    end
  endtask

  task automatic test_done_pulse();
    do_reset();
    fu_ready = 1'b1;
    dispatch(4'd1, 1'b1, 32'd1, 1'b1, 32'd1);
    dispatch(4'd1, 1'b1, 32'd2, 1'b1, 32'd2);
    dispatch(4'd1, 1'b1, 32'd3, 1'b1, 32'd3);
    tick();
    fu_ready = 1'b0;
    fu_done = 1'b1; fu_done_tag = 4'd5; fu_result = 32'h55;
    tick();
    tests_run++;
    if (done_rs !== 16'h0000 || data_rs[5] !== 32'd0) begin
      tests_failed++;
      $display("FAIL done_ignored: done_rs=%h data5=%h, want 0000/0", done_rs, data_rs[5]);
    end
    fu_done_tag = 4'd2; fu_result = 32'hABCD;
    tick();
    fu_done = 1'b0;
    tests_run++;
    if (done_rs !== 16'h0004 || data_rs[2] !== 32'hABCD || rsidx_alloc !== 32'd3) begin
      tests_failed++;
      $display("FAIL done_pulse: done_rs=%h data2=%h alloc=%0d, want 0004/abcd/3", done_rs, data_rs[2], rsidx_alloc);
    end
    tick();
    tests_run++;
    if (done_rs !== 16'h0000 || rsidx_alloc !== 32'd2 || data_rs[2] !== 32'hABCD) begin
      tests_failed++;
      $display("FAIL done_free: done_rs=%h alloc=%0d data2=%h, want 0000/2/abcd", done_rs, rsidx_alloc, data_rs[2]);
    end
  endtask

  task automatic test_full();
    int tag_errs;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      dispatch(4'(i), 1'b1, 32'(i + 100), 1'b1, 32'(i + 200));
    end
    tests_run++;
    if (rs_full !== 1'b1 || rsidx_alloc !== 32'd0) begin
      tests_failed++;
      $display("FAIL full_flag: rs_full=%b alloc=%0d, want 1/0", rs_full, rsidx_alloc);
    end
    dispatch(4'd15, 1'b1, 32'hDEAD, 1'b1, 32'hBEEF);
    tests_run++;
    if (rs_full !== 1'b1 || fu_valid !== 1'b1 || fu_tag !== 4'd0 || fu_a !== 32'd100 || fu_b !== 32'd200 || fu_op !== 4'd0) begin
      tests_failed++;
      $display("FAIL full_ignore: full=%b valid=%b tag=%0d a=%0d b=%0d op=%0d, want 1/1/0/100/200/0", rs_full, fu_valid, fu_tag, fu_a, fu_b, fu_op);
    end
    fu_ready = 1'b1;
    tag_errs = 0;
    for (int i = 0; i < 10; i++) begin
      if (fu_tag !== 4'(i) || fu_a !== 32'(i + 100)) tag_errs++;
      tick();
    end
    fu_ready = 1'b0;
    tests_run++;
    if (tag_errs !== 0) begin
      tests_failed++;
      $display("FAIL full_issue_order: %0d out-of-order issues, want 0", tag_errs);
    end
    fu_done = 1'b1; fu_done_tag = 4'd9; fu_result = 32'h99;
    tick();
    fu_done = 1'b0;
    tests_run++;
    if (done_rs !== 16'h0200 || rs_full !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_done9: done_rs=%h rs_full=%b, want 0200/1", done_rs, rs_full);
    end
    tick();
    tests_run++;
    if (rs_full !== 1'b0 || rsidx_alloc !== 32'd9) begin
      tests_failed++;
      $display("FAIL full_free9: rs_full=%b alloc=%0d, want 0/9", rs_full, rsidx_alloc);
    end
  endtask

  task automatic test_stall();
    int stall_errs;
    do_reset();
    dispatch(4'd3, 1'b1, 32'h30, 1'b1, 32'h31);
    stall_errs = 0;
    for (int i = 0; i < 4; i++) begin
      if (fu_valid !== 1'b1 || fu_a !== 32'h30 || fu_b !== 32'h31 || fu_op !== 4'd3 || fu_tag !== 4'd0) stall_errs++;
      tick();
    end
    tests_run++;
    if (stall_errs !== 0) begin
      tests_failed++;
      $display("FAIL stall_hold: %0d unstable cycles, want 0", stall_errs);
    end
    fu_ready = 1'b1;
    tick();
    fu_ready = 1'b0;
    tests_run++;
    if (fu_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_release: fu_valid=%b, want 0", fu_valid);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    fu_ready = 1'b1;
    dispatch(4'd4, 1'b1, 32'h40, 1'b1, 32'h41);
    tick();
    fu_ready = 1'b0;
    rst = 1'b0;
    #1;
    tests_run++;
    if (fu_valid !== 1'b0 || rs_full !== 1'b0 || rsidx_alloc !== 32'd0) begin
      tests_failed++;
      $display("FAIL midflight_reset: valid=%b full=%b alloc=%0d, want 0/0/0", fu_valid, rs_full, rsidx_alloc);
    end
    tick();
    rst = 1'b1;
    fu_done = 1'b1; fu_done_tag = 4'd0; fu_result = 32'h77;
    tick();
    fu_done = 1'b0;
    tests_run++;
    if (done_rs !== 16'h0000 || data_rs[0] !== 32'd0) begin
      tests_failed++;
      $display("FAIL midflight_stale_done: done_rs=%h data0=%h, want 0000/0", done_rs, data_rs[0]);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    done_rob[4] = 1'b1;
    data_rob[4] = 32'h22;
    dispatch(4'd5, 1'b0, 32'd4, 1'b1, 32'd2);
`ifdef RS_DISPATCH_BYPASS_EN
    tests_run++;
    if (fu_valid !== 1'b1 || fu_a !== 32'h22) begin
      tests_failed++;
      $display("FAIL bypass_on: valid=%b a=%h, want 1/22", fu_valid, fu_a);
    end
`else
    tests_run++;
    if (fu_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bypass_off_wait: valid=%b, want 0", fu_valid);
    end
    tick();
    tests_run++;
    if (fu_valid !== 1'b1 || fu_a !== 32'h22 || fu_b !== 32'd2) begin
      tests_failed++;
      $display("FAIL bypass_off_issue: valid=%b a=%h b=%h, want 1/22/2", fu_valid, fu_a, fu_b);
    end
`endif
  endtask

  task automatic test_concurrent();
    do_reset();
    dispatch(4'd1, 1'b1, 32'd1, 1'b1, 32'd1);
    dispatch(4'd6, 1'b0, 32'd5, 1'b1, 32'h66);
    fu_ready = 1'b1;
    tick();
    fu_ready = 1'b0;
    load_rs_dec = 1'b1; op_dec = 4'd7;
    src1_rdy_dec = 1'b1; src1_dec = 32'hA;
    src2_rdy_dec = 1'b1; src2_dec = 32'hB;
    done_rob[5] = 1'b1; data_rob[5] = 32'h55;
    fu_done = 1'b1; fu_done_tag = 4'd0; fu_result = 32'hE0;
    tick();
    clear_inputs();
    #1;
    tests_run++;
    if (done_rs !== 16'h0001 || data_rs[0] !== 32'hE0 || rsidx_alloc !== 32'd3) begin
      tests_failed++;
      $display("FAIL concurrent_state: done_rs=%h data0=%h alloc=%0d, want 0001/e0/3", done_rs, data_rs[0], rsidx_alloc);
    end
    tests_run++;
    if (fu_valid !== 1'b1 || fu_tag !== 4'd1 || fu_a !== 32'h55 || fu_b !== 32'h66 || fu_op !== 4'd6) begin
      tests_failed++;
      $display("FAIL concurrent_issue: valid=%b tag=%0d a=%h b=%h op=%0d, want 1/1/55/66/6", fu_valid, fu_tag, fu_a, fu_b, fu_op);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b0;
    clear_inputs();
    test_reset();
    test_basic_issue();
    test_capture();
    test_done_pulse();
    test_full();
    test_stall();
    test_reset_midflight();
    test_bypass();
    test_concurrent();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
